btb_ras_predictor: RTL and testbench

//  Parametrised branch target buffer with a circular return-address stack (RAS) and RAS checkpoint/restore.
//  IF looks up fetch_pc; a registered prediction is returned the next cycle. ID/EX trains entries and drives RAS push/pop/restore.

---
 rtl/btb_pkg.sv | 28 ++
 rtl/btb_ras_predictor_if.sv | 40 ++++
 rtl/btb_ras.sv | 56 +++++
 rtl/btb_ras_predictor.sv | 155 +++++++++++++++
 tb/tb_btb_ras_predictor.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/btb_pkg.sv
// Shared kind encoding, LFSR constants and sizing helpers for the BTB/RAS predictor.
package btb_pkg;

  typedef enum logic [1:0] {
    KIND_COND = 2'd0,
    KIND_JMP  = 2'd1,
    KIND_CALL = 2'd2,
    KIND_RET  = 2'd3
  } kind_e;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // x^8 + x^6 + x^5 + x^4 + 1
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic int cnt_init(input int cnt_w);
    return 1 << (cnt_w - 1);
  endfunction

  // Checkpoint is {ptr, count}; count needs one more code than ptr to hold "full".
  function automatic int ckpt_w(input int depth);
    return $clog2(depth) + $clog2(depth + 1);
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/btb_ras_predictor_if.sv
// Fetch-lookup and training bus between the front end (master) and the predictor (slave).
interface btb_ras_predictor_if
  import btb_pkg::*;
#(
  parameter int IDX_W = 4,
  parameter int CP_W  = 7
);
  logic              fetch_en;
  logic [31:0]       fetch_pc;
  logic              pred_valid;
  logic              pred_taken;
  logic [31:0]       pred_target;
  logic [IDX_W-1:0]  pred_index;
  logic [CP_W-1:0]   pred_ras_ptr;

  logic              upd_en;
  logic [31:0]       upd_pc;
  logic [IDX_W-1:0]  upd_index;
  logic              upd_hit;
  kind_e             upd_kind;
  logic              upd_taken;
  logic [31:0]       upd_target;
  logic              upd_mispred;
  logic              ras_restore;
  logic [CP_W-1:0]   upd_ras_ptr;

  modport master (
    output fetch_en, fetch_pc,
    input  pred_valid, pred_taken, pred_target, pred_index, pred_ras_ptr,
    output upd_en, upd_pc, upd_index, upd_hit, upd_kind, upd_taken,
    output upd_target, upd_mispred, ras_restore, upd_ras_ptr
  );

  modport slave (
    input  fetch_en, fetch_pc,
    output pred_valid, pred_taken, pred_target, pred_index, pred_ras_ptr,
    input  upd_en, upd_pc, upd_index, upd_hit, upd_kind, upd_taken,
    input  upd_target, upd_mispred, ras_restore, upd_ras_ptr
  );
endinterface

// File: rtl/btb_ras.sv
// Circular return-address stack: push overwrites the oldest slot when full, pop on empty is ignored.
// A restore reloads ptr/count first so a same-cycle push/pop applies on top of the checkpoint.
module btb_ras #(
  parameter int DEPTH = 8,
  parameter int RP_W  = $clog2(DEPTH),
  parameter int RC_W  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [31:0]     push_dat_i,
  input  logic            restore_i,
  input  logic [RP_W-1:0] restore_ptr_i,
  input  logic [RC_W-1:0] restore_cnt_i,
  output logic [31:0]     top_o,
  output logic [RP_W-1:0] ptr_o,
  output logic [RC_W-1:0] cnt_o
);
  logic [31:0]     mem_q [DEPTH];
  logic [RP_W-1:0] ptr_q, ptr_d, base_ptr;
  logic [RC_W-1:0] cnt_q, cnt_d, base_cnt;

  always_comb begin
    base_ptr = restore_i ? restore_ptr_i : ptr_q;
    base_cnt = restore_i ? restore_cnt_i : cnt_q;
    ptr_d    = base_ptr;
    cnt_d    = base_cnt;
    if (push_i) begin
      ptr_d = base_ptr + 1'b1;
      cnt_d = (base_cnt == RC_W'(DEPTH)) ? base_cnt : base_cnt + 1'b1;
    end else if (pop_i && base_cnt != '0) begin
      ptr_d = base_ptr - 1'b1;
      cnt_d = base_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Slot contents are only meaningful below count, so they need no reset.
  always_ff @(posedge clk) begin
    if (push_i && !reset) mem_q[base_ptr] <= push_dat_i;
  end

  assign top_o = mem_q[ptr_q - 1'b1];
  assign ptr_o = ptr_q;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/btb_ras_predictor.sv
// Branch target buffer with saturating direction counters and a checkpointed circular RAS; 1-cycle lookup.
// Optional `BTB_STATS_EN adds saturating lookup/hit/mispredict counters.
module btb_ras_predictor
  import btb_pkg::*;
#(
  parameter int ENTRIES   = 16,
  parameter int CNT_W     = 2,
  parameter int RAS_DEPTH = 8
) (
  input  logic clk,
  input  logic reset,
  btb_ras_predictor_if.slave bp_if
`ifdef BTB_STATS_EN
  ,
  output logic [31:0] stat_lookups,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_mispred
`endif
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int RP_W  = $clog2(RAS_DEPTH);
  localparam int RC_W  = $clog2(RAS_DEPTH + 1);
  localparam int CP_W  = ckpt_w(RAS_DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(cnt_init(CNT_W));

  logic [ENTRIES-1:0] valid_q;
  logic [29:0]        tag_q  [ENTRIES];
  logic [29:0]        tgt_q  [ENTRIES];
  kind_e              kind_q [ENTRIES];
  logic [CNT_W-1:0]   cnt_q  [ENTRIES];
  logic [7:0]         lfsr_q, lfsr_d;

  logic              pred_valid_q, pred_taken_q;
  logic [31:0]       pred_target_q;
  logic [IDX_W-1:0]  pred_index_q;
  logic [CP_W-1:0]   pred_ras_ptr_q;

  logic [31:0]      ras_top;
  logic [RP_W-1:0]  ras_ptr;
  logic [RC_W-1:0]  ras_cnt;

  logic             hit, lk_valid, lk_taken;
  logic [IDX_W-1:0] hit_idx, alloc_idx;
  logic [31:0]      lk_target;
  logic             do_alloc, do_fix, do_train;
  logic [CNT_W-1:0] cnt_cur, cnt_trn;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && tag_q[i] == bp_if.fetch_pc[31:2]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
    // A return with nothing on the stack has no usable target.
    lk_valid  = hit && !(kind_q[hit_idx] == KIND_RET && ras_cnt == '0);
    lk_taken  = hit && ((kind_q[hit_idx] == KIND_COND) ? cnt_q[hit_idx][CNT_W-1] : 1'b1);
    lk_target = !hit ? '0 :
                (kind_q[hit_idx] == KIND_RET) ? ras_top : {tgt_q[hit_idx], 2'b00};
  end

  always_comb begin
    alloc_idx = lfsr_q[IDX_W-1:0];
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) alloc_idx = IDX_W'(i);
    end
    do_alloc = bp_if.upd_en && !bp_if.upd_hit &&
               (bp_if.upd_taken || bp_if.upd_kind != KIND_COND);
    do_fix   = bp_if.upd_en && bp_if.upd_hit && bp_if.upd_kind != KIND_RET &&
               tgt_q[bp_if.upd_index] != bp_if.upd_target[31:2];
    do_train = bp_if.upd_en && bp_if.upd_hit && bp_if.upd_kind == KIND_COND;
    cnt_cur  = cnt_q[bp_if.upd_index];
    if (bp_if.upd_taken) cnt_trn = (cnt_cur == '1) ? cnt_cur : cnt_cur + 1'b1;
    else                 cnt_trn = (cnt_cur == '0) ? cnt_cur : cnt_cur - 1'b1;
  end

  assign lfsr_d = lfsr_next(lfsr_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      lfsr_q  <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
      if (do_alloc) valid_q[alloc_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_alloc) begin
      tag_q[alloc_idx]  <= bp_if.upd_pc[31:2];
      tgt_q[alloc_idx]  <= bp_if.upd_target[31:2];
      kind_q[alloc_idx] <= bp_if.upd_kind;
      cnt_q[alloc_idx]  <= CNT_INIT;
    end else if (do_fix) begin
      tgt_q[bp_if.upd_index] <= bp_if.upd_target[31:2];
      cnt_q[bp_if.upd_index] <= CNT_INIT;
    end else if (do_train) begin
      cnt_q[bp_if.upd_index] <= cnt_trn;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pred_valid_q   <= 1'b0;
      pred_taken_q   <= 1'b0;
      pred_target_q  <= '0;
      pred_index_q   <= '0;
      pred_ras_ptr_q <= '0;
    end else if (bp_if.fetch_en) begin
      pred_valid_q   <= lk_valid;
      pred_taken_q   <= lk_taken;
      pred_target_q  <= lk_target;
      pred_index_q   <= hit_idx;
      pred_ras_ptr_q <= {ras_ptr, ras_cnt};
    end
  end

  assign bp_if.pred_valid   = pred_valid_q;
  assign bp_if.pred_taken   = pred_taken_q;
  assign bp_if.pred_target  = pred_target_q;
  assign bp_if.pred_index   = pred_index_q;
  assign bp_if.pred_ras_ptr = pred_ras_ptr_q;

  btb_ras #(.DEPTH(RAS_DEPTH)) u_ras (
    .clk          (clk),
    .reset        (reset),
    .push_i       (bp_if.upd_en && bp_if.upd_kind == KIND_CALL),
    .pop_i        (bp_if.upd_en && bp_if.upd_kind == KIND_RET),
    .push_dat_i   ({bp_if.upd_pc[31:2] + 30'd1, 2'b00}),
    .restore_i    (bp_if.ras_restore),
    .restore_ptr_i(bp_if.upd_ras_ptr[CP_W-1 -: RP_W]),
    .restore_cnt_i(bp_if.upd_ras_ptr[RC_W-1:0]),
    .top_o        (ras_top),
    .ptr_o        (ras_ptr),
    .cnt_o        (ras_cnt)
  );

`ifdef BTB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_lookups <= '0;
      stat_hits    <= '0;
      stat_mispred <= '0;
    end else begin
      if (bp_if.fetch_en && stat_lookups != '1) stat_lookups <= stat_lookups + 32'd1;
      if (bp_if.fetch_en && lk_valid && stat_hits != '1) stat_hits <= stat_hits + 32'd1;
      if (bp_if.upd_en && bp_if.upd_mispred && stat_mispred != '1)
        stat_mispred <= stat_mispred + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_btb_ras_predictor.sv
// Bench for btb_ras_predictor: directed scenarios plus random traffic against a behavioural model.
module tb_btb_ras_predictor;
  import btb_pkg::*;

  localparam int ENTRIES = 16, CNT_W = 2, RAS_DEPTH = 8, IDX_W = 4, CP_W = 7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  btb_ras_predictor_if #(.IDX_W(IDX_W), .CP_W(CP_W)) bp_if ();
  btb_ras_predictor #(.ENTRIES(ENTRIES), .CNT_W(CNT_W), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk(clk), .reset(reset), .bp_if(bp_if)
  );

  int n_chk = 0, n_fail = 0;

  // Reference model state
  bit          m_valid [ENTRIES];
  logic [31:0] m_pc    [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_kind  [ENTRIES];
  int          m_cnt   [ENTRIES];
  logic [31:0] m_ras   [RAS_DEPTH];
  int          m_rp, m_rc;
  logic [7:0]  m_lfsr;

  bit          e_valid, e_taken;
  logic [31:0] e_target;
  int          e_index;
  logic [CP_W-1:0] e_ckpt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int find(input logic [31:0] pc);
    int r = -1;
    for (int i = 0; i < ENTRIES; i++)
      if (m_valid[i] && m_pc[i] == {pc[31:2], 2'b00}) r = i;
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    m_rp = 0; m_rc = 0; m_lfsr = 8'hA5;
    e_valid = 0; e_taken = 0; e_target = '0; e_index = 0; e_ckpt = '0;
  endtask

  task automatic do_reset(input bit fe);
    reset = 1'b1;
    bp_if.fetch_en = fe; bp_if.fetch_pc = 32'h1000;
    bp_if.upd_en = 1'b0; bp_if.ras_restore = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; bp_if.fetch_en = 1'b0;
    model_clear();
    chk("rst_valid",  32'(bp_if.pred_valid), 0);
    chk("rst_taken",  32'(bp_if.pred_taken), 0);
    chk("rst_target", bp_if.pred_target, 0);
    chk("rst_index",  32'(bp_if.pred_index), 0);
    chk("rst_ckpt",   32'(bp_if.pred_ras_ptr), 0);
  endtask

  task automatic step(input bit fe, input logic [31:0] fpc,
                      input bit ue, input logic [31:0] upc, input int kind,
                      input bit tk, input logic [31:0] tgt,
                      input bit rr, input logic [CP_W-1:0] rck);
    int h, u, ai;
    logic [7:0] l;
    u = find(upc);
    bp_if.fetch_en = fe;  bp_if.fetch_pc = fpc;
    bp_if.upd_en = ue;    bp_if.upd_pc = upc;
    bp_if.upd_hit = (u >= 0);
    bp_if.upd_index = (u >= 0) ? IDX_W'(u) : '0;
    bp_if.upd_kind = kind_e'(kind[1:0]);
    bp_if.upd_taken = tk; bp_if.upd_target = tgt; bp_if.upd_mispred = 1'b0;
    bp_if.ras_restore = rr; bp_if.upd_ras_ptr = rck;

    // Lookup observes state from before this cycle's update
    if (fe) begin
      h = find(fpc);
      e_ckpt = CP_W'((m_rp << 4) | m_rc);
      e_valid = (h >= 0) && !(h >= 0 && m_kind[h] == 3 && m_rc == 0);
      if (h >= 0) begin
        e_index  = h;
        e_taken  = (m_kind[h] == 0) ? (m_cnt[h] >= 2 ** (CNT_W - 1)) : 1'b1;
        e_target = (m_kind[h] == 3) ? m_ras[(m_rp + RAS_DEPTH - 1) % RAS_DEPTH] : m_tgt[h];
      end
    end
    if (rr) begin m_rp = int'(rck) >> 4; m_rc = int'(rck) & 15; end
    if (ue) begin
      if (u < 0 && (tk || kind != 0)) begin
        ai = -1;
        for (int i = 0; i < ENTRIES; i++) if (!m_valid[i] && ai < 0) ai = i;
        if (ai < 0) ai = int'(m_lfsr) % ENTRIES;
        m_valid[ai] = 1'b1; m_pc[ai] = {upc[31:2], 2'b00};
        m_tgt[ai] = {tgt[31:2], 2'b00}; m_kind[ai] = kind; m_cnt[ai] = 2 ** (CNT_W - 1);
      end else if (u >= 0 && kind != 3 && m_tgt[u] != {tgt[31:2], 2'b00}) begin
        m_tgt[u] = {tgt[31:2], 2'b00}; m_cnt[u] = 2 ** (CNT_W - 1);
      end else if (u >= 0 && kind == 0) begin
        if (tk) m_cnt[u] = (m_cnt[u] + 1 > 2 ** CNT_W - 1) ? 2 ** CNT_W - 1 : m_cnt[u] + 1;
        else    m_cnt[u] = (m_cnt[u] == 0) ? 0 : m_cnt[u] - 1;
      end
      if (kind == 2) begin
        m_ras[m_rp] = {upc[31:2], 2'b00} + 32'd4;
        m_rp = (m_rp + 1) % RAS_DEPTH;
        m_rc = (m_rc == RAS_DEPTH) ? RAS_DEPTH : m_rc + 1;
      end else if (kind == 3 && m_rc > 0) begin
        m_rp = (m_rp + RAS_DEPTH - 1) % RAS_DEPTH;
        m_rc = m_rc - 1;
      end
    end
    @(posedge clk); #1;
    l = m_lfsr;
    m_lfsr = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    bp_if.fetch_en = 1'b0; bp_if.upd_en = 1'b0; bp_if.ras_restore = 1'b0;
    chk("valid", 32'(bp_if.pred_valid), 32'(e_valid));
    chk("ckpt",  32'(bp_if.pred_ras_ptr), 32'(e_ckpt));
    if (e_valid) begin
      chk("taken",  32'(bp_if.pred_taken), 32'(e_taken));
      chk("target", bp_if.pred_target, e_target);
      chk("index",  32'(bp_if.pred_index), 32'(e_index));
    end
  endtask

  task automatic fetch(input logic [31:0] pc);
    step(1, pc, 0, 32'h0, 0, 0, 32'h0, 0, '0);
  endtask

  task automatic upd(input logic [31:0] pc, input int kind, input bit tk, input logic [31:0] tgt);
    step(0, 32'h0, 1, pc, kind, tk, tgt, 0, '0);
  endtask

  initial begin
    int hits;
    logic [CP_W-1:0] ck;
    bp_if.fetch_en = 0; bp_if.fetch_pc = 0; bp_if.upd_en = 0; bp_if.upd_pc = 0;
    bp_if.upd_index = 0; bp_if.upd_hit = 0; bp_if.upd_kind = KIND_COND; bp_if.upd_taken = 0;
    bp_if.upd_target = 0; bp_if.upd_mispred = 0; bp_if.ras_restore = 0; bp_if.upd_ras_ptr = 0;
    @(posedge clk); #1;

    // Reset (with a fetch pending), then cold lookup
    do_reset(1'b1);
    fetch(32'h1000);
    chk("cold_valid", 32'(bp_if.pred_valid), 0);

    // Allocate, then counter training and saturation at 0
    upd(32'h1000, 0, 1, 32'h2000);
    fetch(32'h1000);
    chk("alloc_valid",  32'(bp_if.pred_valid), 1);
    chk("alloc_taken",  32'(bp_if.pred_taken), 1);
    chk("alloc_target", bp_if.pred_target, 32'h2000);
    chk("alloc_index",  32'(bp_if.pred_index), 0);
    repeat (2) upd(32'h1000, 0, 0, 32'h2000);
    fetch(32'h1000);
    chk("nt2_taken", 32'(bp_if.pred_taken), 0);
    repeat (3) upd(32'h1000, 0, 0, 32'h2000);
    upd(32'h1000, 0, 1, 32'h2000);
    fetch(32'h1000);
    chk("sat0_taken", 32'(bp_if.pred_taken), 0);
    // Target fix resets to weakly taken
    upd(32'h1000, 0, 1, 32'h3000);
    fetch(32'h1000);
    chk("fix_target", bp_if.pred_target, 32'h3000);
    chk("fix_taken", 32'(bp_if.pred_taken), 1);

    // Fill the table, then force an LFSR replacement
    do_reset(1'b0);
    for (int i = 0; i < ENTRIES; i++) upd(32'h4000 + 32'(i) * 32'h10, 1, 1, 32'h6000 + 32'(i) * 32'h10);
    upd(32'h4000 + 32'(ENTRIES) * 32'h10, 1, 1, 32'h7000);
    hits = 0;
    for (int i = 0; i <= ENTRIES; i++) begin
      fetch(32'h4000 + 32'(i) * 32'h10);
      hits += int'(bp_if.pred_valid);
    end
    chk("fill_hits", 32'(hits), 32'(ENTRIES));

    // RAS overflow wraps: 9 calls, 8 returns pop newest-first, then empty
    do_reset(1'b0);
    upd(32'h5000, 3, 1, 32'h0);
    for (int k = 1; k <= 9; k++) upd(32'h100 * 32'(k), 2, 1, 32'hA000);
    for (int j = 0; j < 8; j++) begin
      step(1, 32'h5000, 1, 32'h5000, 3, 1, 32'h0, 0, '0);
      chk("ret_target", bp_if.pred_target, 32'h904 - 32'h100 * 32'(j));
    end
    fetch(32'h5000);
    chk("ret_empty_valid", 32'(bp_if.pred_valid), 0);

    // Checkpoint and restore after wrong-path pops/push
    do_reset(1'b0);
    upd(32'h5000, 3, 1, 32'h0);
    upd(32'h300, 2, 1, 32'hA000);
    upd(32'h600, 2, 1, 32'hA000);
    fetch(32'h5000);
    chk("ck_target", bp_if.pred_target, 32'h604);
    chk("ck_value", 32'(bp_if.pred_ras_ptr), 32'h22);
    ck = e_ckpt;
    repeat (2) upd(32'h5000, 3, 1, 32'h0);
    upd(32'h700, 2, 1, 32'hA000);
    step(0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 1, ck);
    fetch(32'h5000);
    chk("restore_target", bp_if.pred_target, 32'h604);
    step(0, 32'h0, 1, 32'h5000, 3, 1, 32'h0, 1, ck);
    fetch(32'h5000);
    chk("restore_pop_target", bp_if.pred_target, 32'h704);

    // Random traffic against the model
    do_reset(1'b0);
    ck = '0;
    for (int n = 0; n < 3000; n++) begin
      int i, f, kind;
      i = $urandom_range(0, 23);
      kind = (i % 6 < 3) ? 0 : (i % 6) - 2;
      f = $urandom_range(0, 24);
      step($urandom_range(0, 1) == 1, (f == 24) ? 32'hF000 : 32'h8000 + 32'(f) * 32'h40,
           $urandom_range(0, 2) != 0, 32'h8000 + 32'(i) * 32'h40, kind,
           $urandom_range(0, 3) != 0,
           32'h10000 + 32'(i) * 32'h100 + 32'($urandom_range(0, 3)) * 32'h10,
           $urandom_range(0, 15) == 0, ck);
      if (bp_if.pred_ras_ptr == e_ckpt) ck = e_ckpt;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
